// File: rtl/exec_unit_pkg.sv
// Shared type definitions for the execute stage.
//   op_t         : 3-bit ALU operation code driven on exec_unit.Op
//   exec_state_t : execute-stage sequencer states
package exec_unit_pkg;

    typedef enum logic [2:0] {
        kADD   = 3'b000,
        kSUB   = 3'b001,
        kAND   = 3'b010,
        kXOR   = 3'b011,
        kSHL   = 3'b100,
        kSHR   = 3'b101,
        kMUL   = 3'b110,
        kPASSB = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } exec_state_t;

endpackage

// File: rtl/exec_unit_mul_seq.sv
// Iterative unsigned shift-add multiplier used by exec_unit for Op MUL.
// Ports:
//   Clk, Reset : clock, synchronous active-high reset
//   Go         : load A/B, clear accumulator and bit counter
//   A, B       : multiplicand / multiplier (sampled only on Go)
//   Last       : high while the final partial product is being added
//   Product    : accumulator plus the current partial product; equals the
//                full 2W-bit product while Last is high
module mul_seq
    import exec_unit_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic           Go,
    input  logic [W-1:0]   A,
    input  logic [W-1:0]   B,
    output logic           Last,
    output logic [2*W-1:0] Product
);

    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [2*W-1:0] acc_q, acc_d;
    logic [CW-1:0]  count_q, count_d;
    logic [2*W-1:0] addend;

    always_comb begin
        addend = '0;
        if (b_q[count_q]) begin
            addend = {{W{1'b0}}, a_q} << count_q;
        end
        // Product is combinational so the owner can capture the final
        // product on the same edge that adds the last partial product.
        Product = acc_q + addend;
        Last    = (count_q == CW'(W - 1));

        a_d     = a_q;
        b_d     = b_q;
        acc_d   = Product;
        count_d = Last ? '0 : count_q + CW'(1);
        if (Go) begin
            a_d     = A;
            b_d     = B;
            acc_d   = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            count_q <= '0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/exec_unit.sv
// Execute stage: one ALU operation per accepted Start, registered Result
// and a one-cycle Done strobe (register file write enable).
// Ports:
//   Clk, Reset         : clock, synchronous active-high reset
//   Start, Op          : request and operation code (sampled when not Busy)
//   OperandA, OperandB : register file reads R1 / R2
//   Result, CarryOut   : registered result and carry/borrow/shift-out/overflow
//   Zero               : Result == 0
//   Busy               : MUL iterating
//   Done               : one-cycle completion strobe
// Build option: define EXEC_MUL_EN to build the iterative multiplier;
// otherwise Op MUL completes in one cycle with Result 0, CarryOut 1.
module exec_unit
    import exec_unit_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    input  op_t          Op,
    input  logic [W-1:0] OperandA,
    input  logic [W-1:0] OperandB,
    output logic [W-1:0] Result,
    output logic         CarryOut,
    output logic         Zero,
    output logic         Busy,
    output logic         Done
);

    exec_state_t  state_q, state_d;
    logic [W-1:0] result_q, result_d;
    logic         carry_q, carry_d;

    logic [W-1:0] alu_res;
    logic         alu_carry;
    logic [W:0]   sum;
    logic [W:0]   diff;

`ifdef EXEC_MUL_EN
    logic           mul_go;
    logic           mul_last;
    logic [2*W-1:0] mul_product;

    mul_seq #(.W(W)) u_mul_seq (
        .Clk     (Clk),
        .Reset   (Reset),
        .Go      (mul_go),
        .A       (OperandA),
        .B       (OperandB),
        .Last    (mul_last),
        .Product (mul_product)
    );
`endif

    always_comb begin
        sum       = {1'b0, OperandA} + {1'b0, OperandB};
        diff      = {1'b0, OperandA} - {1'b0, OperandB};
        alu_res   = '0;
        alu_carry = 1'b0;
        case (Op)
            kADD:   begin alu_res = sum[W-1:0];        alu_carry = sum[W];         end
            kSUB:   begin alu_res = diff[W-1:0];       alu_carry = diff[W];        end
            kAND:   begin alu_res = OperandA & OperandB;                           end
            kXOR:   begin alu_res = OperandA ^ OperandB;                           end
            kSHL:   begin alu_res = OperandA << 1;     alu_carry = OperandA[W-1];  end
            kSHR:   begin alu_res = OperandA >> 1;     alu_carry = OperandA[0];    end
            // Single-cycle MUL means the multiplier is not built: flag it.
            kMUL:   begin alu_res = '0;                alu_carry = 1'b1;           end
            kPASSB: begin alu_res = OperandB;                                      end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        carry_d  = carry_q;
`ifdef EXEC_MUL_EN
        mul_go   = 1'b0;
`endif
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (Start) begin
`ifdef EXEC_MUL_EN
                    if (Op == kMUL) begin
                        mul_go  = 1'b1;
                        state_d = MUL;
                    end else begin
                        result_d = alu_res;
                        carry_d  = alu_carry;
                        state_d  = DONE;
                    end
`else
                    result_d = alu_res;
                    carry_d  = alu_carry;
                    state_d  = DONE;
`endif
                end
            end
`ifdef EXEC_MUL_EN
            MUL: begin
                if (mul_last) begin
                    result_d = mul_product[W-1:0];
                    carry_d  = |mul_product[2*W-1:W];
                    state_d  = DONE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= IDLE;
            result_q <= '0;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            carry_q  <= carry_d;
        end
    end

    assign Result   = result_q;
    assign CarryOut = carry_q;
    assign Zero     = (result_q == '0);
    assign Done     = (state_q == DONE);
`ifdef EXEC_MUL_EN
    assign Busy     = (state_q == MUL);
`else
    assign Busy     = 1'b0;
`endif

endmodule

// File: tb/tb_exec_unit.sv
module tb_exec_unit;
    import exec_unit_pkg::*;

    localparam int unsigned W = 8;
`ifdef EXEC_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic         Clk = 1'b0;
    logic         Reset;
    logic         Start;
    op_t          Op;
    logic [W-1:0] OperandA;
    logic [W-1:0] OperandB;
    logic [W-1:0] Result;
    logic         CarryOut;
    logic         Zero;
    logic         Busy;
    logic         Done;

    int unsigned  checks = 0;
    int unsigned  errors = 0;
    logic [W-1:0] exp_result;
    logic         exp_carry;

    exec_unit #(.W(W)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Start    (Start),
        .Op       (Op),
        .OperandA (OperandA),
        .OperandB (OperandB),
        .Result   (Result),
        .CarryOut (CarryOut),
        .Zero     (Zero),
        .Busy     (Busy),
        .Done     (Done)
    );

    always #5 Clk = ~Clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: {carry, result} from plain integer arithmetic.
    function automatic logic [W:0] ref_op(input op_t op, input logic [W-1:0] a, input logic [W-1:0] b);
        int unsigned ua, ub, m, r;
        bit c;
        ua = a; ub = b; m = 2 ** W;
        r = 0; c = 1'b0;
        case (op)
            kADD:   begin r = (ua + ub) % m;     c = (ua + ub) >= m; end
            kSUB:   begin r = (ua + m - ub) % m; c = ua < ub;        end
            kAND:   begin r = ua & ub;                               end
            kXOR:   begin r = ua ^ ub;                               end
            kSHL:   begin r = (ua * 2) % m;      c = ua >= m / 2;    end
            kSHR:   begin r = ua / 2;            c = (ua % 2) == 1;  end
            kMUL: begin
                if (MUL_EN) begin r = (ua * ub) % m; c = (ua * ub) >= m; end
                else        begin r = 0;             c = 1'b1;           end
            end
            default: begin r = ub; end
        endcase
        return {c, r[W-1:0]};
    endfunction

    // Issue an op at the current (negedge) time and follow it to Done.
    // noise: pulse Start with ADD while a MUL is iterating (must be ignored).
    task automatic do_op(input op_t op, input logic [W-1:0] a, input logic [W-1:0] b, input bit noise);
        logic [W:0]  r;
        int unsigned lat;
        r   = ref_op(op, a, b);
        lat = (MUL_EN && op == kMUL) ? W + 1 : 1;
        Start = 1'b1; Op = op; OperandA = a; OperandB = b;
        for (int unsigned n = 1; n <= lat; n++) begin
            @(negedge Clk);
            if (n < lat) begin
                check("done_early", Done, 0);
                check("busy_mul", Busy, 1);
                check("result_hold", Result, exp_result);
                check("carry_hold", CarryOut, exp_carry);
            end else begin
                exp_result = r[W-1:0];
                exp_carry  = r[W];
                check("done", Done, 1);
                check("busy_done", Busy, 0);
                check("result", Result, exp_result);
                check("carry", CarryOut, exp_carry);
                check("zero", Zero, exp_result == '0);
            end
            Start = 1'b0;
            if (noise && n + 1 < lat) begin
                Start = 1'b1;
                Op    = kADD;
            end
            OperandA = W'($urandom);
            OperandB = W'($urandom);
        end
    endtask

    task automatic idle_cycle();
        Start = 1'b0;
        @(negedge Clk);
        check("done_idle", Done, 0);
        check("busy_idle", Busy, 0);
        check("result_idle", Result, exp_result);
    endtask

    function automatic logic [W-1:0] pick_val();
        logic [W-1:0] v;
        case ($urandom_range(0, 7))
            0: v = '0;
            1: v = '1;
            2: v = W'(1);
            3: v = W'(1) << (W - 1);
            default: v = W'($urandom);
        endcase
        return v;
    endfunction

    initial begin
        Reset = 1'b1; Start = 1'b0; Op = kADD; OperandA = '0; OperandB = '0;
        exp_result = '0; exp_carry = 1'b0;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        check("rst_result", Result, 0);
        check("rst_zero", Zero, 1);
        check("rst_carry", CarryOut, 0);
        check("rst_busy", Busy, 0);
        check("rst_done", Done, 0);

        do_op(kADD, 8'hF0, 8'h20, 1'b0);
        check("add_plan_res", Result, 8'h10);
        check("add_plan_c", CarryOut, 1);
        do_op(kSUB, 8'h05, 8'h07, 1'b0);
        check("sub_plan_res", Result, 8'hFE);
        check("sub_plan_c", CarryOut, 1);
        idle_cycle();

        do_op(kMUL, 8'h0C, 8'h0B, 1'b1);
        do_op(kSHL, 8'h81, 8'h00, 1'b0);
        check("shl_plan_res", Result, 8'h02);
        check("shl_plan_c", CarryOut, 1);
        idle_cycle();
        do_op(kMUL, 8'h20, 8'h10, 1'b0);
        idle_cycle();
        do_op(kMUL, 8'hFF, 8'hFF, 1'b0);
        idle_cycle();

        // Reset aborts work in flight and clears the outputs.
        do_op(kPASSB, 8'h00, 8'h55, 1'b0);
        idle_cycle();
`ifdef EXEC_MUL_EN
        Start = 1'b1; Op = kMUL; OperandA = 8'h03; OperandB = 8'h05;
        @(negedge Clk);
        Start = 1'b0;
        repeat (2) @(negedge Clk);
        check("busy_pre_rst", Busy, 1);
`endif
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        exp_result = '0; exp_carry = 1'b0;
        check("mrst_result", Result, 0);
        check("mrst_zero", Zero, 1);
        check("mrst_carry", CarryOut, 0);
        check("mrst_busy", Busy, 0);
        check("mrst_done", Done, 0);
        for (int unsigned i = 0; i < W + 2; i++) idle_cycle();
        do_op(kPASSB, 8'hA5, 8'h3C, 1'b0);
        check("passb_plan", Result, 8'h3C);

        for (int unsigned i = 0; i < 150; i++) begin
            do_op(op_t'($urandom_range(0, 7)), pick_val(), pick_val(), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end
        idle_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
